// File: rtl/vga_pkg.sv
// Shared VGA types and timing constants for the pixel fetch block.
// Provides fsm_t, rgb_t, active-area sizes and the FSM next-state helper.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SHOW = 2'd2
  } fsm_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // sof: the X=0,Y=0 sample. SHOW only leaves at a frame start,
  // so a frame is never cut short by EN dropping.
  function automatic fsm_t fsm_next(
    input fsm_t s,
    input logic en,
    input logic sof
  );
    fsm_t n;
    n = s;
    unique case (s)
      IDLE: n = en ? ARM : IDLE;
      ARM: begin
        if (!en)     n = IDLE;
        else if (sof) n = SHOW;
      end
      SHOW: if (sof && !en) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line, cleared to zero on reset.
// Ports: clk, rst, din[WIDTH], dout[WIDTH] (din delayed DEPTH cycles).
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Windowed grey-image fetch from frame memory onto a VGA pixel stream.
// Ports: CLK_VGA/RST, X/Y/SYNC_*, EN, MEM_DATA in; MEM_ADDR/MEM_RD,
// RED/GREEN/BLUE, VGA_HS/VS/BLANK_N, FRAME_DONE out.
// Option VGA_TEST_PATTERN_EN adds TP_SEL (horizontal grey ramp).
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int         IMG_W   = 256,
  parameter int         IMG_H   = 256,
  parameter int         X0      = 192,
  parameter int         Y0      = 112,
  parameter int         MEM_LAT = 2,
  parameter logic [7:0] BORDER  = 8'h20
) (
  input  logic        CLK_VGA,
  input  logic        RST,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic        SYNC_H,
  input  logic        SYNC_V,
  input  logic        SYNC_BLANK,
  input  logic        EN,
  input  logic [7:0]  MEM_DATA,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        TP_SEL,
`endif
  output logic [15:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        FRAME_DONE
);

  fsm_t        st;
  fsm_t        nxt;
  logic        sof;
  logic        iw;
  logic        last;
  logic        show_nx;
  logic        rd_nx;
  logic [31:0] dx;
  logic [31:0] dy;
  logic [15:0] addr_nx;

  assign dx  = 32'(X) - 32'(X0);
  assign dy  = 32'(Y) - 32'(Y0);
  assign sof = (X == 10'd0) && (Y == 10'd0);
  assign nxt = fsm_next(st, EN, sof);

  // Out-of-range coordinates never reach the window compare.
  assign iw = SYNC_BLANK
           && (X < 10'(H_ACTIVE)) && (Y < 10'(V_ACTIVE))
           && (dx < 32'(IMG_W)) && (dy < 32'(IMG_H));
  assign last = (dx == 32'(IMG_W - 1)) && (dy == 32'(IMG_H - 1));
  assign addr_nx = 16'(dy * 32'(IMG_W) + dx);
  assign show_nx = iw && (nxt == SHOW);

`ifdef VGA_TEST_PATTERN_EN
  localparam int CW = 12;
  logic       tp_q;
  logic [7:0] grey_q;
  logic       c_tp;
  logic [7:0] c_grey;
  assign rd_nx = show_nx && !TP_SEL;
`else
  localparam int CW = 3;
  assign rd_nx = show_nx;
`endif

  logic vis_q;
  logic show_q;
  logic done_q;

  // Stage 0: state, window flags and the memory request.
  always_ff @(posedge CLK_VGA or posedge RST) begin
    if (RST) begin
      st       <= IDLE;
      vis_q    <= 1'b0;
      show_q   <= 1'b0;
      done_q   <= 1'b0;
      MEM_RD   <= 1'b0;
      MEM_ADDR <= '0;
`ifdef VGA_TEST_PATTERN_EN
      tp_q     <= 1'b0;
      grey_q   <= '0;
`endif
    end else begin
      st     <= nxt;
      vis_q  <= SYNC_BLANK;
      show_q <= show_nx;
      done_q <= show_nx && last;
      MEM_RD <= rd_nx;
      if (rd_nx)
        MEM_ADDR <= addr_nx;
`ifdef VGA_TEST_PATTERN_EN
      tp_q   <= TP_SEL;
      grey_q <= dx[7:0];
`endif
    end
  end

  // Control flags wait out the memory latency beside the read.
  logic [CW-1:0] ctl_in;
  logic [CW-1:0] ctl_out;
  logic          c_vis;
  logic          c_show;
  logic          c_done;

`ifdef VGA_TEST_PATTERN_EN
  assign ctl_in = {tp_q, grey_q, vis_q, show_q, done_q};
  assign {c_tp, c_grey, c_vis, c_show, c_done} = ctl_out;
`else
  assign ctl_in = {vis_q, show_q, done_q};
  assign {c_vis, c_show, c_done} = ctl_out;
`endif

  vga_delay_line #(.WIDTH(CW), .DEPTH(MEM_LAT)) u_ctl (
    .clk  (CLK_VGA),
    .rst  (RST),
    .din  (ctl_in),
    .dout (ctl_out)
  );

  // Syncs are stored inverted so a cleared line reads as idle
  // (HS=1, VS=1, blanked) during and just after reset.
  logic [2:0] sync_out;

  vga_delay_line #(.WIDTH(3), .DEPTH(MEM_LAT + 2)) u_sync (
    .clk  (CLK_VGA),
    .rst  (RST),
    .din  ({~SYNC_H, ~SYNC_V, SYNC_BLANK}),
    .dout (sync_out)
  );

  assign VGA_HS      = ~sync_out[2];
  assign VGA_VS      = ~sync_out[1];
  assign VGA_BLANK_N = sync_out[0];

  logic [7:0] pix;
`ifdef VGA_TEST_PATTERN_EN
  assign pix = c_tp ? c_grey : MEM_DATA;
`else
  assign pix = MEM_DATA;
`endif

  rgb_t rgb;

  always_ff @(posedge CLK_VGA or posedge RST) begin
    if (RST) begin
      rgb        <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= c_done;
      if (!c_vis)
        rgb <= '0;
      else if (c_show)
        rgb <= {pix, pix, pix};
      else
        rgb <= {BORDER, BORDER, BORDER};
    end
  end

  assign RED   = rgb.r;
  assign GREEN = rgb.g;
  assign BLUE  = rgb.b;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed-vector bench for vga_pixel_fetch with a 2-cycle memory model.
// Frame memory returns addr[7:0]; X/Y are driven directly, not scanned.
module tb_vga_pixel_fetch;

  logic        clk;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        sh;
  logic        sv;
  logic        sb;
  logic        en;
  logic [7:0]  mdata;
  logic [15:0] maddr;
  logic        mrd;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hs;
  logic        vs;
  logic        blank_n;
  logic        done;
`ifdef VGA_TEST_PATTERN_EN
  logic        tp_sel;
`endif

  int n_chk;
  int n_bad;

  vga_pixel_fetch dut (
    .CLK_VGA     (clk),
    .RST         (rst),
    .X           (x),
    .Y           (y),
    .SYNC_H      (sh),
    .SYNC_V      (sv),
    .SYNC_BLANK  (sb),
    .EN          (en),
    .MEM_DATA    (mdata),
`ifdef VGA_TEST_PATTERN_EN
    .TP_SEL      (tp_sel),
`endif
    .MEM_ADDR    (maddr),
    .MEM_RD      (mrd),
    .RED         (red),
    .GREEN       (green),
    .BLUE        (blue),
    .VGA_HS      (hs),
    .VGA_VS      (vs),
    .VGA_BLANK_N (blank_n),
    .FRAME_DONE  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: latency 2 after MEM_ADDR, data = addr[7:0].
  logic [15:0] p0;
  logic [15:0] p1;
  always @(posedge clk) begin
    p0 <= maddr;
    p1 <= p0;
  end
  assign mdata = p1[7:0];

  typedef struct {
    int          x;
    int          y;
    bit          b;
    bit          rd;
    logic [15:0] addr;
    logic [7:0]  rgb;
    bit          dn;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int xi, input int yi, input bit bi);
    x  = 10'(xi);
    y  = 10'(yi);
    sb = bi;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      step(700, 600, 1'b0);
  endtask

  function automatic logic [31:0] rgb3(input logic [7:0] v);
    return {8'h0, v, v, v};
  endfunction

  int hs_low;
  int hs_first;
  int dcnt;

  initial begin
    n_chk = 0;
    n_bad = 0;
    tv[0] = '{200, 120, 1, 1, 16'h0808, 8'h08, 0};
    tv[1] = '{192, 112, 1, 1, 16'h0000, 8'h00, 0};
    tv[2] = '{447, 367, 1, 1, 16'hFFFF, 8'hFF, 1};
    tv[3] = '{448, 120, 1, 0, 16'hFFFF, 8'h20, 0};
    tv[4] = '{191, 120, 1, 0, 16'hFFFF, 8'h20, 0};
    tv[5] = '{100,  50, 1, 0, 16'hFFFF, 8'h20, 0};
    tv[6] = '{100,  50, 0, 0, 16'hFFFF, 8'h00, 0};
    tv[7] = '{200, 120, 0, 0, 16'hFFFF, 8'h00, 0};
    tv[8] = '{300, 200, 1, 1, 16'h586C, 8'h6C, 0};
    tv[9] = '{447, 112, 1, 1, 16'h00FF, 8'hFF, 0};

    rst = 1'b1;
    en  = 1'b0;
    x   = '0;
    y   = '0;
    sh  = 1'b1;
    sv  = 1'b1;
    sb  = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    tp_sel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", 32'(mrd), 32'd0);
    chk("rst_addr", 32'(maddr), 32'd0);
    chk("rst_rgb", {8'h0, red, green, blue}, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_blank", 32'(blank_n), 32'd0);

    // EN from reset: nothing read before the first frame start.
    rst = 1'b0;
    en  = 1'b1;
    step(192, 112, 1'b1);
    chk("arm_rd0", 32'(mrd), 32'd0);
    step(192, 112, 1'b1);
    chk("arm_rd1", 32'(mrd), 32'd0);
    step(0, 0, 1'b0);
    step(192, 112, 1'b1);
    chk("first_rd", 32'(mrd), 32'd1);
    chk("first_addr", 32'(maddr), 32'd0);
    fill(3);

    for (int i = 0; i < 10; i++) begin
      step(tv[i].x, tv[i].y, tv[i].b);
      chk($sformatf("v%0d_rd", i), 32'(mrd), 32'(tv[i].rd));
      chk($sformatf("v%0d_addr", i), 32'(maddr), 32'(tv[i].addr));
      fill(3);
      chk($sformatf("v%0d_rgb", i),
          {8'h0, red, green, blue}, rgb3(tv[i].rgb));
      chk($sformatf("v%0d_blank", i), 32'(blank_n), 32'(tv[i].b));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].dn));
    end

    // Horizontal sync pulse X=656..751 delayed by 4.
    hs_low   = 0;
    hs_first = -1;
    for (int k = 0; k < 120; k++) begin
      sh = !((650 + k) >= 656 && (650 + k) <= 751);
      step(650 + k, 10, 1'b0);
      if (!hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
    end
    sh = 1'b1;
    chk("hs_width", 32'(hs_low), 32'd96);
    chk("hs_delay", 32'(hs_first), 32'd9);

    // EN dropped mid-frame: frame finishes, done pulses once.
    en = 1'b0;
    step(300, 200, 1'b1);
    chk("drop_rd", 32'(mrd), 32'd1);
    dcnt = 0;
    step(447, 367, 1'b1);
    chk("drop_last_rd", 32'(mrd), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (done) dcnt++;
      fill(1);
    end
    chk("done_once", 32'(dcnt), 32'd1);
    step(0, 0, 1'b0);
    step(200, 120, 1'b1);
    chk("idle_rd", 32'(mrd), 32'd0);
    fill(3);
    chk("idle_rgb", {8'h0, red, green, blue}, rgb3(8'h20));

    // ARM with EN low falls back to IDLE.
    en = 1'b1;
    fill(1);
    en = 1'b0;
    fill(1);
    step(0, 0, 1'b0);
    step(200, 120, 1'b1);
    chk("arm_abort_rd", 32'(mrd), 32'd0);

    // Reset mid-frame, then wait for the next frame start.
    en = 1'b1;
    fill(1);
    step(0, 0, 1'b0);
    step(250, 150, 1'b1);
    chk("pre_rst_rd", 32'(mrd), 32'd1);
    chk("pre_rst_addr", 32'(maddr), 32'h263A);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd", 32'(mrd), 32'd0);
    chk("mid_rst_addr", 32'(maddr), 32'd0);
    chk("mid_rst_rgb", {8'h0, red, green, blue}, 32'd0);
    chk("mid_rst_hs", 32'(hs), 32'd1);
    chk("mid_rst_blank", 32'(blank_n), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(250, 151, 1'b1);
    chk("post_rst_rd", 32'(mrd), 32'd0);
    fill(3);
    chk("post_rst_rgb", {8'h0, red, green, blue}, rgb3(8'h20));
    step(0, 0, 1'b0);
    step(250, 151, 1'b1);
    chk("resume_rd", 32'(mrd), 32'd1);
    chk("resume_addr", 32'(maddr), 32'h273A);
    fill(3);
    chk("resume_rgb", {8'h0, red, green, blue}, rgb3(8'h3A));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter IMG_W, default 256, image width in pixels (power of two).
REQ-002 SHALL have parameter IMG_H, default 256, image height in lines.
REQ-003 SHALL have parameter X0, default 192, window left column; Y0, default 112, window top line.
REQ-004 SHALL have parameter MEM_LAT, default 2, frame-memory read latency in cycles (1..4).
REQ-005 SHALL have parameter BORDER, default 8'h20, grey level outside the window.
REQ-006 SHALL have ports: CLK_VGA in 1, pixel clock; RST in 1, reset; one clock, reset asynchronous and active-high.
REQ-007 SHALL have ports: X in 10, column; Y in 10, line; SYNC_H in 1; SYNC_V in 1; SYNC_BLANK in 1 (1 = visible).
REQ-008 SHALL have ports: EN in 1, display request; MEM_DATA in 8, grey pixel from frame memory.
REQ-009 SHALL have ports: MEM_ADDR out 16; MEM_RD out 1, read strobe.
REQ-010 SHALL have ports: RED/GREEN/BLUE out 8 each; VGA_HS, VGA_VS, VGA_BLANK_N out 1 each.
REQ-011 SHALL have ports: FRAME_DONE out 1, single-cycle pulse.

Function
REQ-012 SHALL register stage 0: in-window flag IW = visible & X in [X0,X0+IMG_W) & Y in [Y0,Y0+IMG_H).
REQ-013 SHALL drive MEM_ADDR = (Y-Y0)*IMG_W + (X-X0), truncated to 16 bits, and MEM_RD = IW & state SHOW, both registered in stage 0.
REQ-014 SHALL hold MEM_ADDR at its last value while MEM_RD = 0.
REQ-015 SHALL produce pixel outputs exactly MEM_LAT+2 cycles after the X/Y sample.
REQ-016 SHALL delay SYNC_H, SYNC_V and SYNC_BLANK by the same MEM_LAT+2 cycles onto VGA_HS, VGA_VS and VGA_BLANK_N.
REQ-017 SHALL output RED=GREEN=BLUE=MEM_DATA for in-window pixels in SHOW.
REQ-018 SHALL output BORDER on visible pixels that are outside the window or not in SHOW.
REQ-019 SHALL output 0 on all colour channels when the delayed blank is 0.
REQ-020 SHALL implement FSM IDLE/ARM/SHOW: IDLE->ARM on EN=1; ARM->SHOW when X=0 and Y=0 are sampled.
REQ-021 SHALL, in ARM with EN=0, return to IDLE.
REQ-022 SHALL, in SHOW with EN=0, stay in SHOW until X=0 and Y=0 are sampled, then enter IDLE; frames are never truncated.
REQ-023 SHALL pulse FRAME_DONE for one cycle, aligned to the output of the last window pixel (X0+IMG_W-1, Y0+IMG_H-1), only in SHOW.
REQ-024 SHALL ignore X/Y values at or beyond 640/480 apart from the sync delay.

Reset
REQ-025 SHALL on RST force state IDLE, MEM_RD=0, MEM_ADDR=0, RGB=0, FRAME_DONE=0 and all delay stages to 0.
REQ-026 SHALL force VGA_HS=1, VGA_VS=1 and VGA_BLANK_N=0 during reset.
REQ-027 SHALL, on reset release mid-frame, not enter SHOW before the next X=0,Y=0 sample.

Configuration
REQ-028 SHALL, with VGA_TEST_PATTERN_EN defined, add input TP_SEL (1 bit).
REQ-029 SHALL, with TP_SEL=1 in SHOW, output grey (X-X0)[7:0] for window pixels, hold MEM_RD=0, and keep latency per REQ-015.
REQ-030 SHALL, without VGA_TEST_PATTERN_EN, omit TP_SEL and the ramp logic entirely.

Structure
REQ-031 SHALL take the VGA timing constants (640/480 active), the fsm_t enum {IDLE,ARM,SHOW} and the rgb_t struct from shared package vga_pkg.
REQ-032 SHALL implement the sync and valid delay as sub-module vga_delay_line (parameters WIDTH, DEPTH).

Verification
REQ-033 SHALL check: EN=1 from reset -> MEM_RD first asserted for the sample X=192,Y=112 of the first full frame, with MEM_ADDR=0.
REQ-034 SHALL check: MEM_DATA=addr[7:0] model, MEM_LAT=2, sample X=200,Y=120 -> RGB=8'h08 four cycles later, with MEM_ADDR=0x0808.
REQ-035 SHALL check: sample X=100,Y=50 visible -> RGB=8'h20; in blanking -> RGB=0, VGA_BLANK_N=0.
REQ-036 SHALL check: SYNC_H pulse at X=656..751 -> VGA_HS low for exactly 96 cycles, shifted by MEM_LAT+2.
REQ-037 SHALL check: EN dropped at Y=200 -> frame completes, FRAME_DONE pulses once, next frame shows BORDER only.
REQ-038 SHALL check: RST asserted at Y=150 then released -> outputs at reset values, no MEM_RD until the next frame start.
